uart_mem_loader: RTL and testbench
==================================

UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, clocks per UART bit (100 MHz / 9600).
REQ-002 Parameter WORD_BYTES, default 4, bytes per memory word; word width W = 8*WORD_BYTES.
REQ-003 Parameter ADDR_W, default 9, word-address width; region capacity 2**ADDR_W words.
REQ-004 Parameter NUM_REGIONS, default 2, number of target memories (region 0 = IM, 1 = DM); RSEL_W = max(1,clog2(NUM_REGIONS)).
REQ-005 Parameter TIMEOUT_CLKS, default 40*CLKS_PER_BIT, max idle gap between bytes of one word.
REQ-006 Ports: clk in 1 clock; reset in 1 asynchronous active-high reset; start in 1 one-cycle transfer request; mode in 1 (0 load, 1 dump); region_sel in RSEL_W target region; xfer_len in ADDR_W+1 words to transfer.
REQ-007 Ports: rx_serial in 1 UART line in; tx_serial out 1 UART line out; mem_rdata in W read word of selected region (1-cycle latency).
REQ-008 Ports: mem_sel out NUM_REGIONS one-hot region strobe; mem_we out 1 write strobe; mem_re out 1 read strobe; mem_addr out ADDR_W; mem_wdata out W.
REQ-009 Ports: busy out 1; done out NUM_REGIONS sticky per-region completion; err_timeout out 1 one-cycle pulse.

Function
REQ-010 FSM states IDLE, LOAD_BYTE, LOAD_WRITE, DUMP_READ, DUMP_LATCH, DUMP_SEND, DUMP_WAIT; busy=1 in all but IDLE.
REQ-011 IDLE + start: latch mode, region_sel, xfer_len (clamped to 2**ADDR_W); clear done[region_sel]; word_addr<=0, byte_cnt<=0; go LOAD_BYTE or DUMP_READ.
REQ-012 start while busy ignored; region_sel >= NUM_REGIONS ignored (stays IDLE).
REQ-013 xfer_len==0: done[region] set the cycle after start, no memory access, stay IDLE.
REQ-014 LOAD_BYTE: each rx byte-valid stores byte at lane byte_cnt (little-endian, first byte -> bits 7:0); rx bytes in IDLE/dump discarded.
REQ-015 Last lane received: next cycle LOAD_WRITE drives mem_we=1, mem_sel one-hot, mem_addr=word_addr, mem_wdata=assembled word for exactly one cycle.
REQ-016 After write: word_addr==xfer_len-1 -> set done[region], IDLE; else word_addr+1, byte_cnt 0, LOAD_BYTE.
REQ-017 Timeout: byte_cnt!=0 and TIMEOUT_CLKS clocks without a byte -> discard partial word, byte_cnt<=0, err_timeout pulse, word_addr unchanged; gap counter reloads on every byte.
REQ-018 DUMP_READ: mem_re=1, mem_sel, mem_addr=word_addr one cycle; DUMP_LATCH captures mem_rdata next cycle.
REQ-019 DUMP_SEND: pulse UART Tx data-valid one cycle with lane byte_cnt (LSB lane first); DUMP_WAIT holds until Tx done pulse, then next lane; no fixed inter-byte delay.
REQ-020 Last lane of word_addr==xfer_len-1 sent -> set done[region], IDLE; else word_addr+1, DUMP_READ.
REQ-021 mem_we, mem_re, mem_sel zero outside their strobe cycles; never both we and re.
REQ-022 done bits of other regions unaffected by a transfer; held until their region restarts or reset.

Reset
REQ-023 reset asserted: state IDLE, all counters 0, busy 0, done all 0, err_timeout 0, mem_we/mem_re/mem_sel 0, mem_addr 0, mem_wdata 0, Tx data-valid 0, effective immediately regardless of clock.
REQ-024 Reset mid-transfer abandons it; no further memory strobes; a Tx byte already shifting completes on the line; a partial Rx word is lost.

Structure
REQ-025 Shared package uart_loader_pkg holds FSM state encodings, MODE_LOAD/MODE_DUMP constants, and default CLKS_PER_BIT.
REQ-026 Instantiates existing UART_Rx and UART_Tx with CLKS_PER_BIT passed through; one natural new sub-module uart_word_packer (lane assembly, byte_cnt, timeout counter).

Verification
REQ-027 Load region 0, xfer_len=2, bytes 78 56 34 12 EF BE AD DE -> writes addr0=0x12345678, addr1=0xDEADBEEF, done[0]=1, done[1]=0.
REQ-028 Load region 1, 2 bytes then silence > TIMEOUT_CLKS, then 4 bytes 01 02 03 04 -> one err_timeout pulse, single write addr0=0x04030201.
REQ-029 Dump region 1, xfer_len=1, mem_rdata=0xCAFEF00D -> tx bytes 0D F0 FE CA in order, back-to-back on Tx done, done[1]=1.
REQ-030 start with xfer_len=0 -> done set next cycle, no mem_we/mem_re; start during busy -> no effect.
REQ-031 Assert reset mid-load after 3 words -> outputs at reset values within same cycle; new load restarts at addr 0.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART memory loader
package uart_loader_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 10417;   // 100 MHz / 9600 baud

   localparam logic MODE_LOAD = 1'b0;
   localparam logic MODE_DUMP = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_BYTE,
      ST_LOAD_WRITE,
      ST_DUMP_READ,
      ST_DUMP_LATCH,
      ST_DUMP_SEND,
      ST_DUMP_WAIT
   } loader_state_t;

endpackage

// File: rtl/UART_Rx.sv
// rtl/UART_Rx.sv - 8N1 UART receiver, one-cycle rx_dv pulse per byte
// Ports: clk, reset (async, high); rx_serial line in; rx_dv byte strobe; rx_byte received byte.
module UART_Rx #(
   parameter int CLKS_PER_BIT = 10417
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_serial,
   output logic       rx_dv,
   output logic [7:0] rx_byte
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t     state, next_state;
   logic          rx_meta, rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         state   <= RX_IDLE;
      end else begin
         rx_meta <= rx_serial;
         rx_s    <= rx_meta;
         state   <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         RX_IDLE:  if (!rx_s) next_state = RX_START;
         // a start bit that is high again at mid-bit was a glitch
         RX_START: if (cnt == HALF) next_state = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (cnt == BIT_LAST && bit_idx == 3'd7) next_state = RX_STOP;
         RX_STOP:  if (cnt == BIT_LAST) next_state = RX_IDLE;
         default:  next_state = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         bit_idx <= '0;
         rx_byte <= '0;
         rx_dv   <= 1'b0;
      end else begin
         rx_dv <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
            end
            RX_START: cnt <= (cnt == HALF) ? '0 : cnt + CW'(1);
            RX_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt              <= '0;
                  rx_byte[bit_idx] <= rx_s;
                  bit_idx          <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RX_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  rx_dv <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: rtl/UART_Tx.sv
// rtl/UART_Tx.sv - 8N1 UART transmitter, one-cycle tx_done pulse per byte
// Ports: clk; tx_dv start strobe; tx_byte data; tx_active busy; tx_serial line out; tx_done end-of-frame.
// No reset: a frame already on the line always runs to its stop bit, and every
// register walks back to idle within one frame from any power-up value.
module UART_Tx #(
   parameter int CLKS_PER_BIT = 10417
)(
   input  logic       clk,
   input  logic       tx_dv,
   input  logic [7:0] tx_byte,
   output logic       tx_active,
   output logic       tx_serial,
   output logic       tx_done
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t     state, next_state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    data_q;

   always_ff @(posedge clk) begin
      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         TX_IDLE:  if (tx_dv) next_state = TX_START;
         TX_START: if (cnt == BIT_LAST) next_state = TX_DATA;
         TX_DATA:  if (cnt == BIT_LAST && bit_idx == 3'd7) next_state = TX_STOP;
         TX_STOP:  if (cnt == BIT_LAST) next_state = TX_IDLE;
         default:  next_state = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      tx_done <= 1'b0;
      case (state)
         TX_IDLE: begin
            cnt     <= '0;
            bit_idx <= '0;
            if (tx_dv) data_q <= tx_byte;
         end
         TX_START: cnt <= (cnt == BIT_LAST) ? '0 : cnt + CW'(1);
         TX_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt     <= '0;
               bit_idx <= bit_idx + 3'd1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
         TX_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt     <= '0;
               tx_done <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
         default: cnt <= '0;
      endcase
   end

   always_comb begin
      tx_serial = 1'b1;
      case (state)
         TX_START: tx_serial = 1'b0;
         TX_DATA:  tx_serial = data_q[bit_idx];
         default:  tx_serial = 1'b1;
      endcase
   end

   assign tx_active = (state != TX_IDLE);

endmodule

// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - little-endian byte-to-word assembly with inter-byte timeout
// Ports: clk, reset (async, high); clear restarts at lane 0; enable accepts bytes;
// byte_valid/byte_data incoming byte; word_data assembled word; word_done last lane
// stored this cycle; timeout one-cycle pulse when a partial word is abandoned.
module uart_word_packer #(
   parameter int WORD_BYTES   = 4,
   parameter int TIMEOUT_CLKS = 416680
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    enable,
   input  logic                    byte_valid,
   input  logic [7:0]              byte_data,
   output logic [8*WORD_BYTES-1:0] word_data,
   output logic                    word_done,
   output logic                    timeout
);
   localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int GAP_W  = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(WORD_BYTES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT_CLKS - 1);

   logic [LANE_W-1:0] byte_cnt;
   logic [GAP_W-1:0]  gap;
   logic              take, gap_expired;

   assign take        = enable && byte_valid;
   assign word_done   = take && (byte_cnt == LANE_LAST);
   // the gap only runs while a word is partially assembled
   assign gap_expired = enable && !byte_valid && (byte_cnt != '0) && (gap == GAP_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt  <= '0;
         gap       <= '0;
         word_data <= '0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         if (clear) begin
            byte_cnt  <= '0;
            gap       <= '0;
            word_data <= '0;
         end else if (take) begin
            word_data[8*byte_cnt +: 8] <= byte_data;
            byte_cnt <= (byte_cnt == LANE_LAST) ? '0 : byte_cnt + LANE_W'(1);
            gap      <= '0;
         end else if (gap_expired) begin
            byte_cnt  <= '0;
            gap       <= '0;
            word_data <= '0;
            timeout   <= 1'b1;
         end else if (enable && byte_cnt != '0) begin
            gap <= gap + GAP_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - loads words from UART into a selected memory or dumps them back out
// Ports: clk, reset (async, high); start/mode/region_sel/xfer_len transfer request;
// rx_serial/tx_serial UART lines; mem_rdata read word (1-cycle latency);
// mem_sel/mem_we/mem_re/mem_addr/mem_wdata memory strobes; busy; done sticky per
// region; err_timeout pulse when a partial word is dropped.
module uart_mem_loader
   import uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int WORD_BYTES   = 4,
   parameter int ADDR_W       = 9,
   parameter int NUM_REGIONS  = 2,
   parameter int TIMEOUT_CLKS = 40 * CLKS_PER_BIT,
   parameter int RSEL_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    mode,
   input  logic [RSEL_W-1:0]       region_sel,
   input  logic [ADDR_W:0]         xfer_len,
   input  logic                    rx_serial,
   output logic                    tx_serial,
   input  logic [8*WORD_BYTES-1:0] mem_rdata,
   output logic [NUM_REGIONS-1:0]  mem_sel,
   output logic                    mem_we,
   output logic                    mem_re,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [8*WORD_BYTES-1:0] mem_wdata,
   output logic                    busy,
   output logic [NUM_REGIONS-1:0]  done,
   output logic                    err_timeout
);
   localparam int W      = 8 * WORD_BYTES;
   localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [ADDR_W:0]      CAPACITY     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [RSEL_W:0]      REGION_LIMIT = (RSEL_W + 1)'(NUM_REGIONS);
   localparam logic [LANE_W-1:0]    LANE_LAST    = LANE_W'(WORD_BYTES - 1);
   localparam logic [NUM_REGIONS-1:0] SEL_ONE    = NUM_REGIONS'(1);

   loader_state_t          state, next_state;
   logic [ADDR_W-1:0]      word_addr;
   logic [ADDR_W:0]        len_q, len_clamped;
   logic [RSEL_W-1:0]      region_q;
   logic [LANE_W-1:0]      tx_lane;
   logic [W-1:0]           rdata_q, packed_word;
   logic [NUM_REGIONS-1:0] done_q;

   logic       rx_dv, tx_dv, tx_active, tx_done, word_done;
   logic [7:0] rx_byte, tx_byte;
   logic       region_ok, last_word, last_lane;
   logic       start_go, start_zero, finish, next_word, next_lane;

   assign len_clamped = (xfer_len > CAPACITY) ? CAPACITY : xfer_len;
   assign region_ok   = ({1'b0, region_sel} < REGION_LIMIT);
   assign last_word   = ({1'b0, word_addr} == (len_q - (ADDR_W + 1)'(1)));
   assign last_lane   = (tx_lane == LANE_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      start_go   = 1'b0;
      start_zero = 1'b0;
      finish     = 1'b0;
      next_word  = 1'b0;
      next_lane  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && region_ok) begin
               if (len_clamped == '0) begin
                  start_zero = 1'b1;
               end else begin
                  start_go   = 1'b1;
                  next_state = (mode == MODE_DUMP) ? ST_DUMP_READ : ST_LOAD_BYTE;
               end
            end
         end
         ST_LOAD_BYTE:  if (word_done) next_state = ST_LOAD_WRITE;
         ST_LOAD_WRITE: begin
            if (last_word) begin
               finish     = 1'b1;
               next_state = ST_IDLE;
            end else begin
               next_word  = 1'b1;
               next_state = ST_LOAD_BYTE;
            end
         end
         ST_DUMP_READ:  next_state = ST_DUMP_LATCH;
         ST_DUMP_LATCH: next_state = ST_DUMP_SEND;
         // after a reset the transmitter may still be finishing an old frame
         ST_DUMP_SEND:  if (!tx_active) next_state = ST_DUMP_WAIT;
         ST_DUMP_WAIT: begin
            if (tx_done) begin
               if (!last_lane) begin
                  next_lane  = 1'b1;
                  next_state = ST_DUMP_SEND;
               end else if (last_word) begin
                  finish     = 1'b1;
                  next_state = ST_IDLE;
               end else begin
                  next_word  = 1'b1;
                  next_state = ST_DUMP_READ;
               end
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_addr <= '0;
         len_q     <= '0;
         region_q  <= '0;
         tx_lane   <= '0;
         rdata_q   <= '0;
         done_q    <= '0;
      end else begin
         if (start_go) begin
            region_q           <= region_sel;
            len_q              <= len_clamped;
            word_addr          <= '0;
            tx_lane            <= '0;
            done_q[region_sel] <= 1'b0;
         end
         if (start_zero) done_q[region_sel] <= 1'b1;
         if (next_word)  word_addr <= word_addr + ADDR_W'(1);
         if (next_lane)  tx_lane   <= tx_lane + LANE_W'(1);
         if (state == ST_DUMP_LATCH) begin
            rdata_q <= mem_rdata;
            tx_lane <= '0;
         end
         if (finish) done_q[region_q] <= 1'b1;
      end
   end

   assign busy      = (state != ST_IDLE);
   assign mem_we    = (state == ST_LOAD_WRITE);
   assign mem_re    = (state == ST_DUMP_READ);
   assign mem_sel   = (mem_we || mem_re) ? (SEL_ONE << region_q) : '0;
   assign mem_addr  = word_addr;
   assign mem_wdata = packed_word;
   assign done      = done_q;
   assign tx_dv     = (state == ST_DUMP_SEND) && !tx_active;
   assign tx_byte   = rdata_q[8*tx_lane +: 8];

   UART_Rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rx_serial (rx_serial),
      .rx_dv     (rx_dv),
      .rx_byte   (rx_byte)
   );

   UART_Tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk       (clk),
      .tx_dv     (tx_dv),
      .tx_byte   (tx_byte),
      .tx_active (tx_active),
      .tx_serial (tx_serial),
      .tx_done   (tx_done)
   );

   uart_word_packer #(
      .WORD_BYTES   (WORD_BYTES),
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_go),
      .enable     (state == ST_LOAD_BYTE),
      .byte_valid (rx_dv),
      .byte_data  (rx_byte),
      .word_data  (packed_word),
      .word_done  (word_done),
      .timeout    (err_timeout)
   );

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - directed self-checking bench for uart_mem_loader
module tb_uart_mem_loader;
   localparam int CPB = 4;
   localparam int AW  = 4;
   localparam int NR  = 2;
   localparam int W   = 32;

   logic          clk = 1'b0;
   logic          reset, start, mode;
   logic [0:0]    region_sel;
   logic [AW:0]   xfer_len;
   logic          rx_serial, tx_serial;
   logic [W-1:0]  mem_rdata;
   logic [NR-1:0] mem_sel;
   logic          mem_we, mem_re;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wdata;
   logic          busy;
   logic [NR-1:0] done;
   logic          err_timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_mem_loader #(
      .CLKS_PER_BIT (CPB),
      .WORD_BYTES   (4),
      .ADDR_W       (AW),
      .NUM_REGIONS  (NR),
      .TIMEOUT_CLKS (40 * CPB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mode        (mode),
      .region_sel  (region_sel),
      .xfer_len    (xfer_len),
      .rx_serial   (rx_serial),
      .tx_serial   (tx_serial),
      .mem_rdata   (mem_rdata),
      .mem_sel     (mem_sel),
      .mem_we      (mem_we),
      .mem_re      (mem_re),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .busy        (busy),
      .done        (done),
      .err_timeout (err_timeout)
   );

   // memory model and strobe scoreboard
   logic [W-1:0]  mem0 [16];
   logic [W-1:0]  mem1 [16];
   logic [W-1:0]  wr_data_q [$];
   logic [AW-1:0] wr_addr_q [$];
   logic [NR-1:0] wr_sel_q  [$];
   int cyc = 0, err_cnt = 0, re_cnt = 0, both_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) begin
         wr_data_q.push_back(mem_wdata);
         wr_addr_q.push_back(mem_addr);
         wr_sel_q.push_back(mem_sel);
      end
      if (mem_re) begin
         re_cnt    <= re_cnt + 1;
         mem_rdata <= mem_sel[1] ? mem1[mem_addr] : mem0[mem_addr];
      end
      if (mem_we && mem_re) both_cnt <= both_cnt + 1;
      if (err_timeout) err_cnt <= err_cnt + 1;
   end

   // UART line monitor on tx_serial
   logic [7:0] tx_q [$];
   int         tx_cyc_q [$];
   initial begin
      forever begin
         @(negedge clk);
         if (tx_serial === 1'b0) begin
            int         sc;
            logic [7:0] b;
            sc = cyc;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx_serial;
            end
            repeat (CPB) @(negedge clk);
            tx_q.push_back(b);
            tx_cyc_q.push_back(sc);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_serial = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_serial = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_serial = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic pulse_start(input logic m, input logic r, input logic [AW:0] len);
      mode       = m;
      region_sel = r;
      xfer_len   = len;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, (n < maxc), 1);
   endtask

   task automatic clear_writes();
      wr_data_q.delete();
      wr_addr_q.delete();
      wr_sel_q.delete();
   endtask

   function automatic logic [W-1:0] wd(input int i);
      return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxxxxxx;
   endfunction

   function automatic logic [AW-1:0] wa(input int i);
      return (i < wr_addr_q.size()) ? wr_addr_q[i] : 4'hx;
   endfunction

   function automatic logic [7:0] txb(input int i);
      return (i < tx_q.size()) ? tx_q[i] : 8'hxx;
   endfunction

   initial begin
      int re_base, wr_base;
      logic [7:0] load0_bytes [8];
      logic [7:0] dump_exp [4];
      load0_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      dump_exp    = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};

      reset = 1'b1; start = 1'b0; mode = 1'b0; region_sel = '0; xfer_len = '0;
      rx_serial = 1'b1; mem_rdata = '0;
      for (int i = 0; i < 16; i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_re", mem_re, 0);
      chk("rst_sel", mem_sel, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_err", err_timeout, 0);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      tx_q.delete();
      tx_cyc_q.delete();

      // two-word load into region 0, with a start request while busy
      pulse_start(1'b0, 1'b0, 5'd2);
      chk("load0_busy", busy, 1);
      send_byte(load0_bytes[0]);
      pulse_start(1'b1, 1'b1, 5'd1);
      chk("busy_start_done", done, 2'b00);
      for (int i = 1; i < 8; i++) send_byte(load0_bytes[i]);
      wait_idle(100, "load0_idle");
      chk("load0_nwr", wr_data_q.size(), 2);
      chk("load0_a0", wa(0), 0);
      chk("load0_d0", wd(0), 32'h12345678);
      chk("load0_a1", wa(1), 1);
      chk("load0_d1", wd(1), 32'hDEADBEEF);
      chk("load0_sel", (wr_sel_q.size() > 0) ? wr_sel_q[0] : 2'bxx, 2'b01);
      chk("load0_done", done, 2'b01);
      chk("busy_start_no_read", re_cnt, 0);

      // timeout on a partial word into region 1
      clear_writes();
      pulse_start(1'b0, 1'b1, 5'd1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (300) @(negedge clk);
      chk("to_pulse", err_cnt, 1);
      chk("to_busy", busy, 1);
      chk("to_nowr", wr_data_q.size(), 0);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      wait_idle(100, "to_idle");
      chk("to_nwr", wr_data_q.size(), 1);
      chk("to_a0", wa(0), 0);
      chk("to_d0", wd(0), 32'h04030201);
      chk("to_sel", (wr_sel_q.size() > 0) ? wr_sel_q[0] : 2'bxx, 2'b10);
      chk("to_done", done, 2'b11);
      chk("to_pulse_once", err_cnt, 1);

      // dump one word from region 1
      clear_writes();
      mem1[0] = 32'hCAFEF00D;
      tx_q.delete();
      tx_cyc_q.delete();
      re_base = re_cnt;
      pulse_start(1'b1, 1'b1, 5'd1);
      chk("dump_clr_done", done, 2'b01);
      wait_idle(1000, "dump_idle");
      repeat (5) @(negedge clk);
      chk("dump_nbytes", tx_q.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("dump_b%0d", i), txb(i), dump_exp[i]);
      for (int i = 1; i < 4; i++) begin
         int d;
         d = (i < tx_cyc_q.size()) ? tx_cyc_q[i] - tx_cyc_q[i-1] : 0;
         chk($sformatf("dump_gap%0d", i), (d >= 10 * CPB && d <= 10 * CPB + 4), 1);
      end
      chk("dump_done", done, 2'b11);
      chk("dump_nreads", re_cnt - re_base, 1);
      chk("dump_nowr", wr_data_q.size(), 0);

      // reset in the middle of a five-word load
      clear_writes();
      pulse_start(1'b0, 1'b0, 5'd5);
      for (int i = 0; i < 14; i++) send_byte(8'(i));
      chk("mid_nwr", wr_data_q.size(), 3);
      chk("mid_d2", wd(2), 32'h0B0A0908);
      chk("mid_a2", wa(2), 2);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_re", mem_re, 0);
      chk("mid_rst_sel", mem_sel, 0);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_wdata", mem_wdata, 0);
      chk("mid_rst_done", done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // zero-length transfer
      wr_base = wr_data_q.size();
      re_base = re_cnt;
      pulse_start(1'b0, 1'b1, 5'd0);
      chk("zero_done", done, 2'b10);
      chk("zero_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("zero_nowr", wr_data_q.size() - wr_base, 0);
      chk("zero_nord", re_cnt - re_base, 0);

      // fresh load restarts at address 0
      clear_writes();
      pulse_start(1'b0, 1'b0, 5'd1);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      wait_idle(100, "reload_idle");
      chk("reload_nwr", wr_data_q.size(), 1);
      chk("reload_a0", wa(0), 0);
      chk("reload_d0", wd(0), 32'h44332211);
      chk("reload_done", done, 2'b11);
      chk("never_we_re", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
